// File: rtl/aes_serial_host.sv
// -----------------------------------------------------------------------------
// aes_serial_host
//
// Host-side sequencer for a bit-serial AES-128 target. One run takes a
// plaintext/key pair, sends a one-cycle start pulse on both serial lines,
// shifts both operands out LSB first, idles the lines while the core computes
// (watching the target trigger), shifts the ciphertext in MSB first and hands
// it to the consumer.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. req_ready is high only in IDLE. ct_valid rises
// once the ciphertext is latched, and ct/ct_valid stay stable until ct_ready
// is seen. ct_ready while ct_valid is low is ignored.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   plaintext/key request handshake
//   pt, key           operands, sampled on the request transfer
//   s_out, k_out      serial plaintext / key lines to the target
//   c_in              serial ciphertext line from the target
//   trig_in           target trigger, expected high at some point in WAIT
//   ct, ct_valid/ready ciphertext result handshake
//   busy              high whenever the sequencer is not in IDLE
//   trig_err          sticky: last run saw no trigger during WAIT
//   enc_count         completed runs, wrapping
//   dbg_state         current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module aes_serial_host #(
  parameter int W          = 128,
  parameter int LAT_CYCLES = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     pt,
  input  logic [W-1:0]     key,
  output logic             s_out,
  output logic             k_out,
  input  logic             c_in,
  input  logic             trig_in,
  output logic [W-1:0]     ct,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic             busy,
  output logic             trig_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HSHK = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RECV = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(W - 1);
  localparam logic [LW-1:0]    LAT_LAST = LW'(LAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t         state;
  logic [W-1:0]   pt_sh;
  logic [W-1:0]   key_sh;
  logic [W-1:0]   ct_sh;
  logic [BW-1:0]  bit_cnt;
  logic [LW-1:0]  lat_cnt;
  logic           trig_seen;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pt_sh     <= '0;
      key_sh    <= '0;
      ct_sh     <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
      trig_seen <= 1'b0;
      s_out     <= 1'b0;
      k_out     <= 1'b0;
      ct        <= '0;
      ct_valid  <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      trig_err  <= 1'b0;
      enc_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pt_sh     <= pt;
            key_sh    <= key;
            ct_sh     <= '0;
            trig_seen <= 1'b0;
            trig_err  <= 1'b0;
            // Start pulse is driven during the HSHK cycle.
            s_out     <= 1'b1;
            k_out     <= 1'b1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= ST_HSHK;
          end
        end

        ST_HSHK: begin
          // Bit 0 goes out in the first SEND cycle.
          s_out   <= pt_sh[0];
          k_out   <= key_sh[0];
          pt_sh   <= pt_sh >> 1;
          key_sh  <= key_sh >> 1;
          bit_cnt <= '0;
          state   <= ST_SEND;
        end

        ST_SEND: begin
          // bit_cnt names the bit currently on the lines.
          if (bit_cnt == BIT_LAST) begin
            s_out   <= 1'b0;
            k_out   <= 1'b0;
            lat_cnt <= '0;
            state   <= ST_WAIT;
          end else begin
            s_out   <= pt_sh[0];
            k_out   <= key_sh[0];
            pt_sh   <= pt_sh >> 1;
            key_sh  <= key_sh >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_WAIT: begin
          if (trig_in) trig_seen <= 1'b1;
          if (lat_cnt == LAT_LAST) begin
            // Include this cycle's sample, trig_seen has not caught it yet.
            trig_err <= !(trig_seen || trig_in);
            bit_cnt  <= '0;
            state    <= ST_RECV;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        ST_RECV: begin
          // MSB arrives first, so shifting left lands it at the top.
          ct_sh <= {ct_sh[W-2:0], c_in};
          if (bit_cnt == BIT_LAST) begin
            state <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (!ct_valid) begin
            ct       <= ct_sh;
            ct_valid <= 1'b1;
          end else if (ct_ready) begin
            ct_valid  <= 1'b0;
            enc_count <= enc_count + CNT_ONE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          s_out     <= 1'b0;
          k_out     <= 1'b0;
          ct_valid  <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_serial_host.sv
// -----------------------------------------------------------------------------
// tb_aes_serial_host
//
// Directed + randomized bench for aes_serial_host. A default-size instance is
// driven through whole runs with cycle-accurate expectations derived from the
// frame timeline (HSHK, W data bits, LAT_CYCLES idle, W ciphertext bits, one
// latch cycle). A small instance (W=8, CNT_W=3) exercises enc_count wrap.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_aes_serial_host;

  localparam int W    = 128;
  localparam int LAT  = 40;
  localparam int CW   = 16;
  localparam int SW   = 8;
  localparam int SLAT = 3;
  localparam int SCW  = 3;

  // Timeline of one run, counted in rising edges after the accepting edge 0.
  localparam int WAIT_START = 1 + W;               // first edge in WAIT
  localparam int RECV_START = 1 + W + LAT;         // edge entering RECV
  localparam int VALID_AT   = 2 + 2 * W + LAT;     // 298 at defaults
  localparam int S_RECV     = 1 + SW + SLAT;
  localparam int S_VALID    = 2 + 2 * SW + SLAT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic          req_valid, req_ready, s_out, k_out, c_in, trig_in;
  logic [W-1:0]  pt, key, ct;
  logic          ct_valid, ct_ready, busy, trig_err;
  logic [CW-1:0] enc_count;
  logic [2:0]    dbg_state;

  aes_serial_host #(.W(W), .LAT_CYCLES(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .pt(pt), .key(key),
    .s_out(s_out), .k_out(k_out), .c_in(c_in), .trig_in(trig_in),
    .ct(ct), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .busy(busy), .trig_err(trig_err), .enc_count(enc_count),
    .dbg_state(dbg_state)
  );

  // ---------------- small instance ----------------
  logic           sreq_valid, sreq_ready, ss_out, sk_out, sc_in, strig_in;
  logic [SW-1:0]  spt, skey, sct;
  logic           sct_valid, sct_ready, sbusy, strig_err;
  logic [SCW-1:0] senc_count;
  logic [2:0]     sdbg_state;

  aes_serial_host #(.W(SW), .LAT_CYCLES(SLAT), .CNT_W(SCW)) sdut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sreq_valid), .req_ready(sreq_ready), .pt(spt), .key(skey),
    .s_out(ss_out), .k_out(sk_out), .c_in(sc_in), .trig_in(strig_in),
    .ct(sct), .ct_valid(sct_valid), .ct_ready(sct_ready),
    .busy(sbusy), .trig_err(strig_err), .enc_count(senc_count),
    .dbg_state(sdbg_state)
  );

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];
  int unsigned   exp_count  = 0;
  int unsigned   sexp_count = 0;
  logic [2:0]    idle_state;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver: one full run on the main instance ----------------
  // trig_mode: 0 trigger never high, 1 single pulse inside WAIT,
  //            2 stuck high, 3 pulses only just before and just after WAIT.
  task automatic run_txn(input logic [W-1:0] p, input logic [W-1:0] k,
                         input logic [W-1:0] c, input int trig_mode,
                         input int hold, input string tag);
    logic [168:0] s_cap, k_cap, s_exp, k_exp;
    logic [W-1:0] exp_ct;
    int  first_valid;
    int  pulse_n;
    int  waited;
    bit  hold_ok;
    bit  trig_exp;

    waited = 0;
    while (!req_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_req_ready"}, 256'(req_ready), 256'(1));

    exp_q.push_back(c);
    s_exp       = {40'b0, p, 1'b1};
    k_exp       = {40'b0, k, 1'b1};
    trig_exp    = (trig_mode == 0) || (trig_mode == 3);
    pulse_n     = $urandom_range(WAIT_START, RECV_START - 1);
    first_valid = -1;
    s_cap       = '0;
    k_cap       = '0;

    req_valid = 1'b1;
    pt        = p;
    key       = k;

    for (int n = 0; n <= VALID_AT; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check({tag, "_trig_err_clear"}, 256'(trig_err), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(1));
        check({tag, "_req_ready_low"}, 256'(req_ready), 256'(0));
        check({tag, "_state_left_idle"}, 256'(dbg_state != idle_state), 256'(1));
      end
      if (n <= 168) begin
        s_cap[n] = s_out;
        k_cap[n] = k_out;
      end
      if (ct_valid && first_valid < 0) first_valid = n;

      // Ignored traffic: requests and operand changes mid-run.
      req_valid = (n < VALID_AT - 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      pt        = rand_w();
      key       = rand_w();
      c_in      = (n >= RECV_START && n < RECV_START + W) ? c[W-1-(n-RECV_START)]
                                                          : 1'($urandom_range(0, 1));
      case (trig_mode)
        0:       trig_in = 1'b0;
        1:       trig_in = (n == pulse_n);
        2:       trig_in = 1'b1;
        default: trig_in = (n == WAIT_START - 1) || (n == RECV_START);
      endcase
      if (n < VALID_AT) ct_ready = 1'($urandom_range(0, 1));
      else              ct_ready = (hold == 0);
    end

    exp_ct = exp_q.pop_front();
    check({tag, "_s_frame"}, 256'(s_cap), 256'(s_exp));
    check({tag, "_k_frame"}, 256'(k_cap), 256'(k_exp));
    check({tag, "_latency"}, 256'(first_valid), 256'(VALID_AT));
    check({tag, "_ct"}, 256'(ct), 256'(exp_ct));
    check({tag, "_trig_err"}, 256'(trig_err), 256'(trig_exp));

    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (ct_valid !== 1'b1 || ct !== exp_ct || req_ready !== 1'b0 || busy !== 1'b1)
          hold_ok = 1'b0;
        ct_ready = (h == hold - 1);
      end
      check({tag, "_hold_stable"}, 256'(hold_ok), 256'(1));
    end

    @(negedge clk);
    exp_count = (exp_count + 1) % (1 << CW);
    check({tag, "_ct_valid_drop"}, 256'(ct_valid), 256'(0));
    check({tag, "_enc_count"}, 256'(enc_count), 256'(exp_count));
    check({tag, "_idle_ready"}, 256'(req_ready), 256'(1));
    check({tag, "_idle_busy"}, 256'(busy), 256'(0));
    check({tag, "_trig_err_sticky"}, 256'(trig_err), 256'(trig_exp));
    ct_ready = 1'b0;
    trig_in  = 1'b0;
  endtask

  // ---------------- driver: reset asserted in the middle of SEND ----------------
  task automatic reset_mid_send();
    req_valid = 1'b1;
    pt        = '1;
    key       = '1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("rst_pre_s_out", 256'(s_out), 256'(1));
    check("rst_pre_busy", 256'(busy), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_s_out", 256'(s_out), 256'(0));
    check("rst_k_out", 256'(k_out), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_ct_valid", 256'(ct_valid), 256'(0));
    check("rst_enc_count", 256'(enc_count), 256'(0));
    check("rst_ct", 256'(ct), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst_release_ready", 256'(req_ready), 256'(1));
  endtask

  // ---------------- driver: one run on the small instance ----------------
  task automatic run_small(input logic [SW-1:0] p, input logic [SW-1:0] k,
                           input logic [SW-1:0] c, input int idx);
    int first_valid;
    int waited;
    waited = 0;
    while (!sreq_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("small%0d_ready", idx), 256'(sreq_ready), 256'(1));
    first_valid = -1;
    sreq_valid  = 1'b1;
    spt         = p;
    skey        = k;
    for (int n = 0; n <= S_VALID; n++) begin
      @(negedge clk);
      if (sct_valid && first_valid < 0) first_valid = n;
      sreq_valid = 1'b0;
      spt        = 8'($urandom);
      skey       = 8'($urandom);
      sc_in      = (n >= S_RECV && n < S_RECV + SW) ? c[SW-1-(n-S_RECV)]
                                                    : 1'($urandom_range(0, 1));
      strig_in   = 1'($urandom_range(0, 1));
    end
    check($sformatf("small%0d_latency", idx), 256'(first_valid), 256'(S_VALID));
    check($sformatf("small%0d_ct", idx), 256'(sct), 256'(c));
    sct_ready = 1'b1;
    @(negedge clk);
    sct_ready  = 1'b0;
    sexp_count = (sexp_count + 1) % (1 << SCW);
    check($sformatf("small%0d_enc_count", idx), 256'(senc_count), 256'(sexp_count));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;  pt  = '0;  key  = '0;  c_in  = 1'b0;
    trig_in    = 1'b0;  ct_ready  = 1'b0;
    sreq_valid = 1'b0;  spt = '0;  skey = '0;  sc_in = 1'b0;
    strig_in   = 1'b0;  sct_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_state = dbg_state;

    // Reset values.
    check("reset_s_out", 256'(s_out), 256'(0));
    check("reset_k_out", 256'(k_out), 256'(0));
    check("reset_ct", 256'(ct), 256'(0));
    check("reset_ct_valid", 256'(ct_valid), 256'(0));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_trig_err", 256'(trig_err), 256'(0));
    check("reset_enc_count", 256'(enc_count), 256'(0));
    check("reset_req_ready", 256'(req_ready), 256'(1));
    check("reset_small_count", 256'(senc_count), 256'(0));

    // FIPS-197 appendix C.1 vector; the target's reply is modelled as the known ciphertext.
    run_txn(128'h00112233445566778899aabbccddeeff,
            128'h000102030405060708090a0b0c0d0e0f,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 0, "fips");

    // Missing trigger, then a run with a trigger pulse clears the error.
    run_txn(rand_w(), rand_w(), rand_w(), 0, 0, "notrig");
    run_txn(rand_w(), rand_w(), rand_w(), 1, 0, "trigpulse");

    // Frame shape: single plaintext bit, all-ones key; trigger stuck high.
    run_txn(128'h1, '1, rand_w(), 2, 0, "frame");

    // Trigger only on the cycles bordering WAIT must not count.
    run_txn(rand_w(), rand_w(), rand_w(), 3, 0, "trig_edge");

    // Consumer stalls for 50 cycles.
    run_txn(rand_w(), rand_w(), rand_w(), 1, 50, "stall");

    // Random runs.
    for (int r = 0; r < 3; r++)
      run_txn(rand_w(), rand_w(), rand_w(), $urandom_range(0, 3),
              $urandom_range(0, 5), $sformatf("rand%0d", r));

    // Reset mid-run, then normal operation resumes with a cleared count.
    reset_mid_send();
    run_txn(rand_w(), rand_w(), rand_w(), 1, 0, "post_reset");

    // Small instance: nine runs take a 3-bit counter through 7 -> 0.
    for (int r = 0; r < 9; r++)
      run_small(8'($urandom), 8'($urandom), 8'($urandom), r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
